// File: rtl/stack_spill_fill.sv
// Stack spill/fill engine.
// Keeps the bottom of a hardware stack in a small local deque. When the deque
// fills, its oldest entry is written to a memory spill area. When it drains,
// the most recently spilled word is read back in below the current bottom.
// The core pushes and pops at the top end; the memory side works at the
// bottom end. Both ends may change in the same cycle.

module stack_spill_fill #(
  parameter int WIDTH      = 32,
  parameter int BUF_DEPTH  = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      bottom,
  output logic [WIDTH-1:0]      refill,
  output logic                  refill_valid,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_ack,
  output logic                  overflow
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int IW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned DEPTH_U = BUF_DEPTH;
  localparam logic [CW-1:0] CNT_FULL   = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] CNT_ALMOST = CW'(BUF_DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         buf_cnt, buf_cnt_nxt;
  logic [ADDR_WIDTH-1:0] mem_cnt, mem_cnt_nxt;
  logic [IW-1:0]         bot_ptr, bot_ptr_nxt;
  logic [WIDTH-1:0]      buf_mem [BUF_DEPTH];

  logic          buf_full, buf_empty, mem_full, mem_empty;
  logic          push_acc, pop_acc, spill_ack, fill_ack;
  logic [IW-1:0] top_idx, wr_top_idx, under_idx, next_bot_idx;

  // The deque is circular, so every slot index wraps at the buffer depth.
  function automatic logic [IW-1:0] wrap_idx(input int unsigned v);
    return IW'(v % DEPTH_U);
  endfunction

  // Occupancy flags, handshake qualification and the stall rule.
  always_comb begin
    buf_full     = (buf_cnt == CNT_FULL);
    buf_empty    = (buf_cnt == '0);
    mem_full     = (mem_cnt == '1);
    mem_empty    = (mem_cnt == '0);
    stall        = buf_full
                 | (buf_empty & ~mem_empty)
                 | ((state == SPILL) & (buf_cnt <= CNT_ONE))
                 | ((state == FILL)  & (buf_cnt >= CNT_ALMOST));
    push_acc     = push & ~pop & ~stall & ~buf_full;
    pop_acc      = pop & ~push & ~stall & ~buf_empty;
    spill_ack    = (state == SPILL) & mem_ack;
    fill_ack     = (state == FILL) & mem_ack;
    top_idx      = wrap_idx(32'(bot_ptr) + 32'(buf_cnt) + DEPTH_U - 32'd1);
    wr_top_idx   = wrap_idx(32'(bot_ptr) + 32'(buf_cnt));
    under_idx    = wrap_idx(32'(bot_ptr) + DEPTH_U - 32'd1);
    next_bot_idx = wrap_idx(32'(bot_ptr) + 32'd1);
    overflow     = mem_full;
    refill_valid = ~buf_empty;
    refill       = buf_empty ? '0 : buf_mem[top_idx];
  end

  // Core and memory deltas are summed so a coinciding ack and push/pop both land.
  always_comb begin
    buf_cnt_nxt = buf_cnt;
    mem_cnt_nxt = mem_cnt;
    bot_ptr_nxt = bot_ptr;
    if (push_acc)  buf_cnt_nxt = buf_cnt_nxt + CNT_ONE;
    if (fill_ack)  buf_cnt_nxt = buf_cnt_nxt + CNT_ONE;
    if (pop_acc)   buf_cnt_nxt = buf_cnt_nxt - CNT_ONE;
    if (spill_ack) buf_cnt_nxt = buf_cnt_nxt - CNT_ONE;
    if (spill_ack) begin
      mem_cnt_nxt = mem_cnt + A_ONE;
      bot_ptr_nxt = next_bot_idx;
    end
    if (fill_ack) begin
      mem_cnt_nxt = mem_cnt - A_ONE;
      bot_ptr_nxt = under_idx;
    end
  end

  // Occupancy counters and bottom pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_cnt <= '0;
      mem_cnt <= '0;
      bot_ptr <= '0;
    end else begin
      buf_cnt <= buf_cnt_nxt;
      mem_cnt <= mem_cnt_nxt;
      bot_ptr <= bot_ptr_nxt;
    end
  end

  // Deque storage: pushes land above the top, fills land below the bottom.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (push_acc) buf_mem[wr_top_idx] <= bottom;
      if (fill_ack) buf_mem[under_idx]  <= mem_rdata;
    end
  end

  // Memory-side FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Start a spill near full or a fill near empty; always return to IDLE on ack.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (buf_cnt >= CNT_ALMOST && !mem_full)    state_nxt = SPILL;
        else if (buf_cnt <= CNT_ONE && !mem_empty) state_nxt = FILL;
      end
      SPILL:   if (mem_ack) state_nxt = IDLE;
      FILL:    if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory request outputs; address and data depend only on registered state.
  always_comb begin
    mem_req   = (state != IDLE);
    mem_we    = (state == SPILL);
    mem_addr  = (state == FILL) ? (BASE + mem_cnt - A_ONE) : (BASE + mem_cnt);
    mem_wdata = buf_mem[bot_ptr];
  end

endmodule

// File: doc/stack_spill_fill.md
STACK_SPILL_FILL -- requirements
Module: stack_spill_fill

Interface
REQ-001 Parameter WIDTH, default 32, element width in bits.
REQ-002 Parameter BUF_DEPTH, default 4, local buffer entries; SHALL be >= 4.
REQ-003 Parameter ADDR_WIDTH, default 16, memory word-address width.
REQ-004 Parameter BASE_ADDR, default 0, memory address of spill slot 0.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 push  input  1  stack shifted down this cycle; bottom element leaves the stack.
REQ-008 pop  input  1  stack shifted up this cycle; bottom slot needs a refill value.
REQ-009 bottom  input  WIDTH  value leaving the stack bottom, valid with push.
REQ-010 refill  output  WIDTH  value the stack loads into its bottom slot on pop.
REQ-011 refill_valid  output  1  refill holds real data.
REQ-012 stall  output  1  core SHALL NOT push or pop this cycle.
REQ-013 mem_req / mem_we  output  1 / 1  memory request; write (spill) vs read (fill).
REQ-014 mem_addr  output  ADDR_WIDTH  memory word address.
REQ-015 mem_wdata  output  WIDTH  spill data.
REQ-016 mem_rdata / mem_ack  input  WIDTH / 1  fill data valid in ack cycle; request completion.
REQ-017 overflow  output  1  memory spill area full.

Function
REQ-018 Local buffer SHALL be a deque: push/pop act at the top end, spill/fill at the bottom end; buf_cnt 0..BUF_DEPTH, mem_cnt 0..2^ADDR_WIDTH-1.
REQ-019 Accepted push (push & ~pop & ~stall & buf_cnt<BUF_DEPTH): bottom written to top slot, buf_cnt+1.
REQ-020 refill SHALL be the top buffer entry combinationally, refill_valid = (buf_cnt!=0); refill = 0 when buf_cnt==0.
REQ-021 Accepted pop (pop & ~push & ~stall & buf_cnt!=0): top entry removed, buf_cnt-1.
REQ-022 push & pop same cycle SHALL be a no-op; pop with buf_cnt==0 and mem_cnt==0 SHALL be ignored (underflow, no state change).
REQ-023 stall = (buf_cnt==BUF_DEPTH) | (buf_cnt==0 & mem_cnt!=0) | (state==SPILL & buf_cnt<=1) | (state==FILL & buf_cnt>=BUF_DEPTH-1).
REQ-024 FSM states IDLE, SPILL, FILL; mem_req = (state!=IDLE), mem_we = (state==SPILL).
REQ-025 IDLE->SPILL when registered buf_cnt>=BUF_DEPTH-1 and mem_cnt!=2^ADDR_WIDTH-1; mem_req rises the following cycle.
REQ-026 IDLE->FILL when registered buf_cnt<=1 and mem_cnt!=0; SPILL takes priority if both hold.
REQ-027 SPILL: mem_addr = BASE_ADDR+mem_cnt, mem_wdata = bottom buffer entry, held stable until mem_ack.
REQ-028 FILL: mem_addr = BASE_ADDR+mem_cnt-1, held stable until mem_ack; address arithmetic modulo 2^ADDR_WIDTH.
REQ-029 SPILL ack: bottom entry released, buf_cnt-1, mem_cnt+1, state->IDLE.
REQ-030 FILL ack: mem_rdata written below current bottom, buf_cnt+1, mem_cnt-1, state->IDLE.
REQ-031 Ack coinciding with accepted push/pop: both count deltas SHALL apply in the same cycle.
REQ-032 FSM SHALL spend at least one cycle in IDLE between transactions; mem_ack outside SPILL/FILL ignored.
REQ-033 overflow = (mem_cnt==2^ADDR_WIDTH-1), combinational; no spill issued while high.

Reset
REQ-034 reset SHALL force state IDLE, buf_cnt 0, mem_cnt 0, pointers 0; outputs then mem_req 0, stall 0, refill_valid 0, refill 0, overflow 0.
REQ-035 reset mid-transaction SHALL abandon the request; mem_req low the cycle after the reset edge.

Verification (BUF_DEPTH=4, ADDR_WIDTH=4, BASE_ADDR=8)
REQ-036 Reset; push 0xA,0xB,0xC -> next cycle mem_req=1, mem_we=1, mem_addr=8, mem_wdata=0xA; ack -> mem_cnt=1, buf_cnt=2.
REQ-037 Hold mem_ack low during spill, push to buf_cnt=4 -> stall=1, further push ignored, mem_addr/mem_wdata unchanged.
REQ-038 After 2 spills (0xA,0xB) pop until buf_cnt=1 -> mem_req=1, mem_we=0, mem_addr=9; ack rdata=0xB -> subsequent pops yield refill 0xC?,0xB,0xA in LIFO order.
REQ-039 push & pop together with buf_cnt=2 -> buf_cnt, refill, mem_cnt unchanged.
REQ-040 Pop on empty (buf_cnt=0, mem_cnt=0) -> refill_valid=0, stall=0, counts unchanged.
REQ-041 Assert reset while mem_req=1 -> following cycle mem_req=0, buf_cnt=0, mem_cnt=0, refill_valid=0.
